// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Unsigned add clamped to the largest w-bit value.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_event_fifo.sv
// Small valid/ready spike event FIFO; a push into a full FIFO is dropped
// unless a pop frees a slot in the same cycle.
module lif_event_fifo
    import lif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_drop
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop_fire;
    logic          w_push_fire;

    assign w_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_data      = r_mem[r_rd_ptr];
    assign w_pop_fire  = i_en & i_pop & ~o_empty;
    assign w_push_fire = i_en & i_push & (~w_full | w_pop_fire);
    assign o_drop      = i_en & i_push & w_full & ~w_pop_fire;

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_fire) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop_fire) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Shares one leaky integrate-and-fire datapath across NUM_NEURONS neurons,
// sweeping them in index order on every timestep tick.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 8,
    parameter int REFRAC      = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int IDX_W      = idx_width(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             tick,
    input  logic [WIDTH-1:0] threshold,
    input  logic [2:0]       leak_shift,
    output logic [IDX_W-1:0] cur_idx,
    input  logic [WIDTH-1:0] cur_in,
    output logic             busy,
    output logic             done,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_idx,
    output logic             ev_overflow,
    output logic             tick_miss,
    input  logic [IDX_W-1:0] mon_sel,
    output logic [WIDTH-1:0] mon_state
);

    localparam int RW = cnt_width(REFRAC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    lif_state_e       r_state;
    lif_state_e       w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_v      [NUM_NEURONS];
    logic [RW-1:0]    r_refrac [NUM_NEURONS];
    logic             r_tick_miss;
    logic             r_overflow;

    logic             w_update;
    logic             w_refractory;
    logic             w_fire;
    logic [WIDTH-1:0] w_v_cur;
    logic [WIDTH-1:0] w_v_leak;
    logic [WIDTH-1:0] w_sum;
    logic [RW-1:0]    w_rf_cur;
    logic             w_fifo_empty;
    logic             w_fifo_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (tick) w_state_next = UPDATE;
            UPDATE:  if (r_idx == LAST_IDX) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == UPDATE);
        done    = (r_state == DONE);
        cur_idx = r_idx;
    end

    // A leak shift of zero means no leak, not "subtract everything".
    assign w_update     = ena & (r_state == UPDATE);
    assign w_v_cur      = r_v[r_idx];
    assign w_rf_cur     = r_refrac[r_idx];
    assign w_refractory = (w_rf_cur != '0);
    assign w_v_leak     = (leak_shift == 3'd0) ? w_v_cur : w_v_cur - (w_v_cur >> leak_shift);
    assign w_sum        = WIDTH'(sat_add(32'(w_v_leak), 32'(cur_in), WIDTH));
    assign w_fire       = w_update & ~w_refractory & (w_sum >= threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_update) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i]      <= '0;
                r_refrac[i] <= '0;
            end
        end else if (w_update) begin
            if (w_refractory) begin
                r_v[r_idx]      <= '0;
                r_refrac[r_idx] <= w_rf_cur - RW'(1);
            end else if (w_fire) begin
                r_v[r_idx]      <= '0;
                r_refrac[r_idx] <= RW'(REFRAC);
            end else begin
                r_v[r_idx]      <= w_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_miss <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (ena && tick && (r_state != IDLE)) begin
                r_tick_miss <= 1'b1;
            end
            if (w_fifo_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    lif_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_event_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (ena),
        .i_push  (w_fire),
        .i_data  (r_idx),
        .i_pop   (ev_ready),
        .o_data  (ev_idx),
        .o_empty (w_fifo_empty),
        .o_drop  (w_fifo_drop)
    );

    assign ev_valid    = ~w_fifo_empty;
    assign ev_overflow = r_overflow;
    assign tick_miss   = r_tick_miss;
    assign mon_state   = r_v[mon_sel];

endmodule
